// File: rtl/instr_decode_pkg.sv
// Shared opcode map, instruction classes and DISPC field layout
// for the registered instruction decode stage.
package instr_decode_pkg;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_BRANCH,
    CLS_ALU_REG,
    CLS_ALU_LIT,
    CLS_DISP,
    CLS_SYS,
    CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic {
    IDLE,
    EMIT
  } dec_state_t;

  localparam logic [5:0] OP_NOOP  = 6'h00;
  localparam logic [5:0] OP_EXIT  = 6'h01;
  localparam logic [5:0] OP_LD    = 6'h18;
  localparam logic [5:0] OP_ST    = 6'h19;
  localparam logic [5:0] OP_DISPC = 6'h1A;
  localparam logic [5:0] OP_JMP   = 6'h1B;
  localparam logic [5:0] OP_BEQ   = 6'h1C;
  localparam logic [5:0] OP_BNE   = 6'h1D;
  localparam logic [5:0] OP_LDR   = 6'h1F;

  // DISPC word: opcode | type | charA | charB | ... (MSB first)
  localparam int OPC_W    = 6;
  localparam int TYPE_W   = 2;
  localparam int TYPE_LSB = 32 - OPC_W - TYPE_W;

  function automatic int char_lsb(int idx, int char_w);
    return TYPE_LSB - (idx + 1) * char_w;
  endfunction

  function automatic int disp_bits(int chars, int char_w);
    return OPC_W + TYPE_W + chars * char_w;
  endfunction

  // ALU function codes 7 and F are holes in both ALU groups
  function automatic logic alu_fn_ok(logic [3:0] fn);
    return (fn != 4'h7) && (fn != 4'hF);
  endfunction

  function automatic instr_class_t class_of(logic [5:0] op);
    instr_class_t c;
    logic is_mem, is_br, is_areg, is_alit, is_disp, is_sys;
    c       = CLS_ILLEGAL;
    is_mem  = (op == OP_LD) || (op == OP_ST)
           || (op == OP_LDR);
    is_br   = (op == OP_JMP) || (op == OP_BEQ)
           || (op == OP_BNE);
    is_areg = (op[5:4] == 2'b10) && alu_fn_ok(op[3:0]);
    is_alit = (op[5:4] == 2'b11) && alu_fn_ok(op[3:0]);
    is_disp = (op == OP_DISPC);
    is_sys  = (op == OP_EXIT) || (op == OP_NOOP);
    unique case (1'b1)
      is_mem:  c = CLS_MEM;
      is_br:   c = CLS_BRANCH;
      is_areg: c = CLS_ALU_REG;
      is_alit: c = CLS_ALU_LIT;
      is_disp: c = CLS_DISP;
      is_sys:  c = CLS_SYS;
      default: c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decode_stage_char_serializer.sv
// Streams the non-NUL characters of a latched DISPC word,
// lowest index (charA) first.
module instr_decode_stage_char_serializer #(
  parameter int CHAR_W = 7,
  parameter int CHARS  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           load,
  input  logic [CHARS-1:0][CHAR_W-1:0]   load_chars,
  input  logic                           chr_ready,
  output logic                           chr_valid,
  output logic [CHAR_W-1:0]              chr_data,
  output logic                           chr_last
);

  logic [CHARS-1:0][CHAR_W-1:0] chars;
  logic [CHARS-1:0] mask;
  logic [CHARS-1:0] first;
  logic [CHARS-1:0] nonnul;

  // NUL mask of the incoming word and lowest pending character
  always_comb begin
    for (int i = 0; i < CHARS; i++) begin
      nonnul[i] = |load_chars[i];
    end
    first = mask & (~mask + 1'b1);
  end

  // Output mux driven by the one-hot next-character select
  always_comb begin
    chr_data = '0;
    for (int i = 0; i < CHARS; i++) begin
      if (first[i]) chr_data = chars[i];
    end
    chr_valid = |mask;
    chr_last  = chr_valid && ((mask & ~first) == '0);
  end

  // Latch on load, retire one character per handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chars <= '0;
      mask  <= '0;
    end else if (flush) begin
      mask <= '0;
    end else if (load) begin
      chars <= load_chars;
      mask  <= nonnul;
    end else if (chr_valid && chr_ready) begin
      mask <= mask & ~first;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered, back-pressurable instruction decode stage with
// a DISPC character serialiser.
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CHAR_W = 7,
  parameter int CHARS  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [5:0]        dec_opcode,
  output instr_class_t      dec_class,
  output logic [REG_W-1:0]  dec_rc,
  output logic [REG_W-1:0]  dec_ra,
  output logic [REG_W-1:0]  dec_rb,
  output logic [DATA_W-1:0] dec_lit,
  output logic              dec_illegal,
  output logic              chr_valid,
  input  logic              chr_ready,
  output logic [CHAR_W-1:0] chr_data,
  output logic [1:0]        chr_type,
  output logic              chr_last
);

  localparam int LIT_W  = 32 - OPC_W - 2 * REG_W;
  localparam int RC_MSB = 31 - OPC_W;
  localparam int RA_MSB = RC_MSB - REG_W;
  localparam int RB_MSB = RA_MSB - REG_W;

  if (disp_bits(CHARS, CHAR_W) > 32) begin : g_bad_layout
    $error("DISPC layout does not fit in 32 bits");
  end

  dec_state_t state;
  logic accept;
  logic is_disp;
  logic any_chr;
  logic chr_done;
  logic [5:0] op;
  instr_class_t cls;
  logic [CHARS-1:0][CHAR_W-1:0] word_chars;

  assign in_ready = (state == IDLE) && !flush
                 && (!dec_valid || dec_ready);
  assign accept   = in_valid && in_ready;
  assign op       = in_instr[31:26];
  assign cls      = class_of(op);
  assign is_disp  = (cls == CLS_DISP);
  assign chr_done = chr_valid && chr_ready && chr_last;

  // Unpack the DISPC character fields, charA first
  always_comb begin
    any_chr = 1'b0;
    for (int i = 0; i < CHARS; i++) begin
      word_chars[i] = in_instr[char_lsb(i, CHAR_W) +: CHAR_W];
      any_chr = any_chr || (|word_chars[i]);
    end
  end

  instr_decode_stage_char_serializer #(
    .CHAR_W (CHAR_W),
    .CHARS  (CHARS)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (accept && is_disp),
    .load_chars (word_chars),
    .chr_ready  (chr_ready),
    .chr_valid  (chr_valid),
    .chr_data   (chr_data),
    .chr_last   (chr_last)
  );

  // Stage FSM and decode output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dec_valid   <= 1'b0;
      dec_opcode  <= '0;
      dec_class   <= CLS_MEM;
      dec_rc      <= '0;
      dec_ra      <= '0;
      dec_rb      <= '0;
      dec_lit     <= '0;
      dec_illegal <= 1'b0;
      chr_type    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      dec_valid <= 1'b0;
    end else begin
      if (accept && !is_disp) begin
        dec_valid   <= 1'b1;
        dec_opcode  <= op;
        dec_class   <= cls;
        dec_rc      <= in_instr[RC_MSB -: REG_W];
        dec_ra      <= in_instr[RA_MSB -: REG_W];
        dec_rb      <= in_instr[RB_MSB -: REG_W];
        dec_lit     <= DATA_W'($signed(in_instr[LIT_W-1:0]));
        dec_illegal <= (cls == CLS_ILLEGAL);
      end else if (dec_ready) begin
        dec_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept && is_disp) begin
            chr_type <= in_instr[TYPE_LSB +: TYPE_W];
            if (any_chr) state <= EMIT;
          end
        end
        EMIT: begin
          if (chr_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed, table-driven bench for instr_decode_stage.
// Decode vectors in a loop, then handshake corner sequences.
module tb_instr_decode_stage;
  import instr_decode_pkg::*;

  logic clk = 1'b0;
  logic reset, flush;
  logic in_valid, in_ready;
  logic [31:0] in_instr;
  logic dec_valid, dec_ready;
  logic [5:0] dec_opcode;
  instr_class_t dec_class;
  logic [4:0] dec_rc, dec_ra, dec_rb;
  logic [31:0] dec_lit;
  logic dec_illegal;
  logic chr_valid, chr_ready;
  logic [6:0] chr_data;
  logic [1:0] chr_type;
  logic chr_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_opcode  (dec_opcode),
    .dec_class   (dec_class),
    .dec_rc      (dec_rc),
    .dec_ra      (dec_ra),
    .dec_rb      (dec_rb),
    .dec_lit     (dec_lit),
    .dec_illegal (dec_illegal),
    .chr_valid   (chr_valid),
    .chr_ready   (chr_ready),
    .chr_data    (chr_data),
    .chr_type    (chr_type),
    .chr_last    (chr_last)
  );

  typedef struct {
    logic [31:0]  instr;
    instr_class_t cls;
    logic [4:0]   rc;
    logic [4:0]   ra;
    logic [4:0]   rb;
    logic [31:0]  lit;
    logic         ill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input int i);
    chk($sformatf("v%0d valid", i), dec_valid, 1);
    chk($sformatf("v%0d op", i), dec_opcode,
        vecs[i].instr[31:26]);
    chk($sformatf("v%0d class", i), dec_class, vecs[i].cls);
    chk($sformatf("v%0d rc", i), dec_rc, vecs[i].rc);
    chk($sformatf("v%0d ra", i), dec_ra, vecs[i].ra);
    chk($sformatf("v%0d rb", i), dec_rb, vecs[i].rb);
    chk($sformatf("v%0d lit", i), dec_lit, vecs[i].lit);
    chk($sformatf("v%0d ill", i), dec_illegal, vecs[i].ill);
  endtask

  initial begin
    vecs[0]  = '{32'hC061FFFB, CLS_ALU_LIT, 3, 1, 31,
                 32'hFFFFFFFB, 0};
    vecs[1]  = '{32'h80221800, CLS_ALU_REG, 1, 2, 3,
                 32'h00001800, 0};
    vecs[2]  = '{32'h60A47FFF, CLS_MEM, 5, 4, 15,
                 32'h00007FFF, 0};
    vecs[3]  = '{32'h73E08000, CLS_BRANCH, 31, 0, 16,
                 32'hFFFF8000, 0};
    vecs[4]  = '{32'hFC000000, CLS_ILLEGAL, 0, 0, 0, 0, 1};
    vecs[5]  = '{32'h9C000000, CLS_ILLEGAL, 0, 0, 0, 0, 1};
    vecs[6]  = '{32'hF8000001, CLS_ALU_LIT, 0, 0, 0, 1, 0};
    vecs[7]  = '{32'h04000000, CLS_SYS, 0, 0, 0, 0, 0};
    vecs[8]  = '{32'h00000000, CLS_SYS, 0, 0, 0, 0, 0};
    vecs[9]  = '{32'h6C000000, CLS_BRANCH, 0, 0, 0, 0, 0};
    vecs[10] = '{32'h64000000, CLS_MEM, 0, 0, 0, 0, 0};
    vecs[11] = '{32'h7C000000, CLS_MEM, 0, 0, 0, 0, 0};
    vecs[12] = '{32'h74000000, CLS_BRANCH, 0, 0, 0, 0, 0};
    vecs[13] = '{32'h78000000, CLS_ILLEGAL, 0, 0, 0, 0, 1};
    vecs[14] = '{32'hBC000000, CLS_ILLEGAL, 0, 0, 0, 0, 1};

    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    dec_ready = 1'b1;
    chr_ready = 1'b1;
    #1;
    chk("rst dec_valid", dec_valid, 0);
    chk("rst chr_valid", chr_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst dec_lit", dec_lit, 0);
    chk("rst chr_data", chr_data, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // back-to-back decode, one word per cycle
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      step();
      chk_vec(i);
    end
    in_valid = 1'b0;
    step();
    chk("drain dec_valid", dec_valid, 0);

    // back-pressure with a second word pending
    dec_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = vecs[1].instr;
    step();
    in_instr = vecs[2].instr;
    #1;
    chk("bp in_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_vec(1);
      chk($sformatf("bp%0d in_ready", c), in_ready, 0);
    end
    dec_ready = 1'b1;
    #1;
    chk("bp release in_ready", in_ready, 1);
    step();
    chk_vec(2);
    in_valid = 1'b0;
    step();
    chk("bp drain", dec_valid, 0);

    // DISPC "Hi"
    in_valid = 1'b1;
    in_instr = 32'h6891A400;
    step();
    in_valid = 1'b0;
    chk("hi c0 valid", chr_valid, 1);
    chk("hi c0 data", chr_data, 7'h48);
    chk("hi c0 last", chr_last, 0);
    chk("hi c0 type", chr_type, 0);
    chk("hi c0 in_ready", in_ready, 0);
    chk("hi dec_valid", dec_valid, 0);
    step();
    chk("hi c1 valid", chr_valid, 1);
    chk("hi c1 data", chr_data, 7'h69);
    chk("hi c1 last", chr_last, 1);
    chk("hi c1 in_ready", in_ready, 0);
    step();
    chk("hi done valid", chr_valid, 0);
    chk("hi done in_ready", in_ready, 1);

    // DISPC 'A',NUL,'B' type 2 with chr back-pressure
    chr_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h6A820210;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("ab hold%0d data", c), chr_data, 7'h41);
      chk($sformatf("ab hold%0d last", c), chr_last, 0);
      chk($sformatf("ab hold%0d type", c), chr_type, 2);
      step();
    end
    chr_ready = 1'b1;
    step();
    chk("ab skip valid", chr_valid, 1);
    chk("ab skip data", chr_data, 7'h42);
    chk("ab skip last", chr_last, 1);
    step();
    chk("ab done valid", chr_valid, 0);

    // all-NUL DISPC is swallowed
    in_valid = 1'b1;
    in_instr = 32'h68000000;
    step();
    in_valid = 1'b0;
    chk("nul chr_valid", chr_valid, 0);
    chk("nul dec_valid", dec_valid, 0);
    chk("nul in_ready", in_ready, 1);

    // flush after first character, offered word dropped
    in_valid = 1'b1;
    in_instr = 32'h6891A400;
    step();
    in_instr = vecs[1].instr;
    flush = 1'b1;
    #1;
    chk("fl c0 data", chr_data, 7'h48);
    chk("fl in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl chr_valid", chr_valid, 0);
    chk("fl dec_valid", dec_valid, 0);
    chk("fl in_ready", in_ready, 1);
    step();
    chk("fl dropped", dec_valid, 0);

    // flush discards a held decode output
    dec_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = vecs[0].instr;
    step();
    in_valid = 1'b0;
    chk("fld held", dec_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fld dec_valid", dec_valid, 0);

    // reset with held decode output
    in_valid = 1'b1;
    in_instr = vecs[0].instr;
    step();
    in_valid = 1'b0;
    chk("rd held", dec_valid, 1);
    reset = 1'b1;
    #1;
    chk("rd dec_valid", dec_valid, 0);
    chk("rd dec_lit", dec_lit, 0);
    chk("rd dec_rc", dec_rc, 0);
    chk("rd in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    dec_ready = 1'b1;
    step();

    // reset in the middle of EMIT
    in_valid = 1'b1;
    in_instr = 32'h6891A400;
    step();
    in_valid = 1'b0;
    chk("re c0 valid", chr_valid, 1);
    reset = 1'b1;
    #1;
    chk("re chr_valid", chr_valid, 0);
    chk("re chr_data", chr_data, 0);
    chk("re chr_last", chr_last, 0);
    chk("re in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("re stays idle", chr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
